mem_stage_stall: RTL
====================

MEM_STAGE_STALL -- requirements
Module: mem_stage_stall

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width.
REQ-002 SHALL have parameter DEPTH, default 64, meaning data-memory words (power of two).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, meaning extra stall cycles per memory access (0 allowed).
REQ-004 SHALL have parameter BASE_ADDR, default 1024, meaning byte address mapped to word 0.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports mem_r_en_in / mem_w_en_in / wb_en_in, inputs, 1 each, meaning load / store / writeback request.
REQ-008 SHALL have port dest_in, input, 4, destination register.
REQ-009 SHALL have ports alu_res and val_rm, inputs, DATA_W each, meaning byte address or result, and store data.
REQ-010 SHALL have port freeze, output, 1, meaning stall request to upstream stages.
REQ-011 SHALL have registered outputs: wb_en_out (1), mem_r_en_out (1), dest_out (4), alu_res_out (DATA_W), mem_out (DATA_W), forming the MEM/WB register.

Function
REQ-012 SHALL form word index = ((alu_res - BASE_ADDR) >> 2) mod DEPTH; out-of-range addresses wrap.
REQ-013 SHALL use an FSM with states IDLE and BUSY, plus a wait counter of width clog2(WAIT_CYCLES+1).
REQ-014 IDLE with no access: SHALL load inputs into MEM/WB in one cycle; freeze=0.
REQ-015 IDLE with an access and WAIT_CYCLES>0: SHALL assert freeze combinationally in the same cycle, load counter=WAIT_CYCLES-1, and go BUSY.
REQ-016 BUSY: SHALL hold freeze=1 while counter!=0 and decrement the counter each cycle.
REQ-017 BUSY with counter==0: SHALL drop freeze; on that edge commit the store or capture the load data into mem_out, load MEM/WB, and return to IDLE.
REQ-018 An access SHALL occupy exactly WAIT_CYCLES+1 cycles; freeze SHALL be high for exactly WAIT_CYCLES of them.
REQ-019 WAIT_CYCLES=0: every access SHALL complete in one cycle with freeze never asserted.
REQ-020 While freeze=1, MEM/WB SHALL load a bubble: wb_en_out=0, mem_r_en_out=0; other fields are don't-care and held.
REQ-021 Inputs SHALL be sampled only on the completing cycle; upstream holds them stable while frozen.
REQ-022 Simultaneous mem_r_en_in and mem_w_en_in: store SHALL take priority, load SHALL be suppressed, and mem_r_en_out SHALL be 0.
REQ-023 Memory SHALL be written only on the completing edge of a store; no partial or early writes.
REQ-024 alu_res_out, dest_out and wb_en_out SHALL pass the inputs through unchanged on completion.

Reset
REQ-025 rst SHALL force IDLE, counter=0, freeze=0, and all MEM/WB outputs to 0 on the next edge.
REQ-026 rst mid-access SHALL abort the access; a pending store SHALL NOT modify memory.
REQ-027 Memory array contents SHALL NOT be cleared by rst.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE, BUSY) and the default BASE_ADDR constant.
REQ-029 The memory array SHALL be one sub-module, data_mem_array: asynchronous read, synchronous write, parameterised by DATA_W and DEPTH.

Verification
REQ-030 WAIT_CYCLES=2: store 0xDEADBEEF to 1028 -> freeze high for 2 cycles, word 1 = 0xDEADBEEF after cycle 3, wb_en_out=0 during the freeze.
REQ-031 Load from 1028 after REQ-030 -> mem_out=0xDEADBEEF and mem_r_en_out=1 exactly 3 cycles after the request.
REQ-032 Non-memory op with alu_res=0x55 and dest=4'h7 -> next cycle alu_res_out=0x55, dest_out=7, freeze never asserted.
REQ-033 Store 0x12345678 to 1024+4*DEPTH -> wraps to word 0; a load from 1024 returns 0x12345678.
REQ-034 Store started, rst asserted in the 2nd freeze cycle -> outputs 0, IDLE, and the target word is unchanged.
REQ-035 WAIT_CYCLES=0 with back-to-back load/store/load -> one cycle each, freeze stays 0, and data is correct.

Source files
------------

// File: rtl/mem_stage_stall_pkg.sv
// rtl/mem_stage_stall_pkg.sv - shared FSM state type and address map constant for the MEM stage
package mem_stage_stall_pkg;

    // Access sequencer states: IDLE accepts a new op, BUSY counts out the wait states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Byte address that maps onto data-memory word 0
    localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/mem_stage_stall_data_mem_array.sv
// rtl/mem_stage_stall_data_mem_array.sv - word-addressed data memory, async read, sync write
module data_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // Contents survive reset on purpose; software may rely on memory across a core reset
    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port, committed only on the edge the caller qualifies
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_stall.sv
// rtl/mem_stage_stall.sv - pipeline MEM stage with fixed wait-state memory and upstream freeze
module mem_stage_stall
    import mem_stage_stall_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic [3:0]        dest_in,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] val_rm,
    output logic              freeze,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [3:0]        dest_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] mem_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter keeps at least one bit so WAIT_CYCLES=0 still elaborates cleanly
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_INIT = HAS_WAIT ? CW'(WAIT_CYCLES - 1) : '0;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              access;
    logic              is_store;
    logic              is_load;
    logic              complete;
    logic              mem_we;
    logic [DATA_W-1:0] byte_off;
    logic [AW-1:0]     word_idx;
    logic [DATA_W-1:0] rdata;

    // Store wins over a simultaneous load; the load half is simply dropped
    assign access   = mem_r_en_in | mem_w_en_in;
    assign is_store = mem_w_en_in;
    assign is_load  = mem_r_en_in & ~mem_w_en_in;

    // Word index wraps modulo DEPTH; byte offset bits [1:0] are ignored
    assign byte_off = alu_res - DATA_W'(BASE_ADDR);
    assign word_idx = AW'(byte_off >> 2);

    // Freeze is combinational so upstream sees the stall in the same cycle the access arrives
    always_comb begin
        freeze = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                freeze = access & HAS_WAIT;
            end else begin
                freeze = (cnt != '0);
            end
        end
    end

    // Any unfrozen, non-reset cycle is the one where inputs are consumed
    assign complete = ~rst & ~freeze;
    assign mem_we   = complete & is_store;

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_data_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (val_rm),
        .rdata (rdata)
    );

    // Access sequencer plus MEM/WB register: bubble while frozen, load on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            dest_out     <= '0;
            alu_res_out  <= '0;
            mem_out      <= '0;
        end else begin
            if (state == IDLE) begin
                if (access && HAS_WAIT) begin
                    state <= BUSY;
                    cnt   <= CNT_INIT;
                end
            end else begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    state <= IDLE;
                end
            end

            if (complete) begin
                wb_en_out    <= wb_en_in;
                mem_r_en_out <= is_load;
                dest_out     <= dest_in;
                alu_res_out  <= alu_res;
                if (is_load) begin
                    mem_out <= rdata;
                end
            end else begin
                wb_en_out    <= 1'b0;
                mem_r_en_out <= 1'b0;
            end
        end
    end

endmodule
